// File: rtl/update_queue.sv
// Buffers edge-weight updates and issues them one per container job; a pushed entry reaches RUN 2 cycles after accept.
// Backpressure: wr_ready = !full; a push while full is dropped and flagged by sticky overflow.
`ifndef PRED_WIDTH
`define PRED_WIDTH 7
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 15
`endif

module update_queue #(
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [`PRED_WIDTH:0]       wr_src,
   input  logic [`PRED_WIDTH:0]       wr_dst,
   input  logic [`WEIGHT_WIDTH:0]     wr_e,
   input  logic [`PRED_WIDTH:0]       cfg_src,
   input  logic                       container_done,
   output logic                       container_reset,
   output logic [`PRED_WIDTH:0]       src,
   output logic [`PRED_WIDTH:0]       u_src,
   output logic [`PRED_WIDTH:0]       u_dst,
   output logic [`WEIGHT_WIDTH:0]     u_e,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     fill,
   output logic [15:0]                jobs_done,
   output logic                       overflow,
   output logic                       timeout
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [31:0] WD_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

   typedef struct packed {
      logic [`PRED_WIDTH:0]   src;
      logic [`PRED_WIDTH:0]   dst;
      logic [`WEIGHT_WIDTH:0] e;
   } upd_t;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

   state_t               state_q, state_d;
   upd_t                 mem_q [DEPTH];
   upd_t                 cur_q, cur_d;
   logic [`PRED_WIDTH:0] src_q, src_d;
   logic [AW-1:0]        wptr_q, rptr_q;
   logic [AW:0]          fill_q, fill_d;
   logic [15:0]          jobs_q, jobs_d;
   logic [31:0]          wd_q, wd_d;
   logic                 ovf_q, tmo_q, tmo_d;
   logic                 full, push, pop;

   assign full = (fill_q == (AW+1)'(DEPTH));
   assign push = wr_valid && !full;

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      src_d   = src_q;
      jobs_d  = jobs_q;
      wd_d    = wd_q;
      tmo_d   = tmo_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (fill_q != '0) begin
               pop     = 1'b1;
               cur_d   = mem_q[rptr_q];
               src_d   = cfg_src;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            wd_d    = 32'd0;
            state_d = S_RUN;
         end
         S_RUN: begin
            wd_d = wd_q + 32'd1;
            // done takes priority over a watchdog expiry in the same cycle
            if (container_done) begin
               jobs_d  = jobs_q + 16'd1;
               state_d = S_IDLE;
            end else if (TIMEOUT_CYCLES != 0 && wd_q == WD_LAST) begin
               tmo_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      fill_d = fill_q;
      case ({push, pop})
         2'b10:   fill_d = fill_q + (AW+1)'(1);
         2'b01:   fill_d = fill_q - (AW+1)'(1);
         default: fill_d = fill_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= '{src: wr_src, dst: wr_dst, e: wr_e};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         src_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         fill_q  <= '0;
         jobs_q  <= '0;
         wd_q    <= '0;
         ovf_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         src_q   <= src_d;
         fill_q  <= fill_d;
         jobs_q  <= jobs_d;
         wd_q    <= wd_d;
         tmo_q   <= tmo_d;
         ovf_q   <= ovf_q | (wr_valid & full);
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
      end
   end

   assign wr_ready        = !full;
   assign container_reset = (state_q != S_RUN);
   assign busy            = (state_q != S_IDLE) || (fill_q != '0);
   assign fill            = fill_q;
   assign src             = src_q;
   assign u_src           = cur_q.src;
   assign u_dst           = cur_q.dst;
   assign u_e             = cur_q.e;
   assign jobs_done       = jobs_q;
   assign overflow        = ovf_q;
   assign timeout         = tmo_q;
endmodule

// File: tb/tb_update_queue.sv
// Directed bench for update_queue: dut a has the watchdog disabled, dut b uses an 8-cycle watchdog.
`ifndef PRED_WIDTH
`define PRED_WIDTH 7
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 15
`endif

module tb_update_queue;
   typedef logic [`PRED_WIDTH:0]   pred_t;
   typedef logic [`WEIGHT_WIDTH:0] wt_t;

   logic  clk = 1'b0;
   logic  reset_n, wr_valid, container_done;
   pred_t wr_src, wr_dst, cfg_src;
   wt_t   wr_e;

   logic        a_wr_ready, a_cr, a_busy, a_ovf, a_tmo;
   pred_t       a_src, a_u_src, a_u_dst;
   wt_t         a_u_e;
   logic [4:0]  a_fill;
   logic [15:0] a_jobs;
   logic        b_wr_ready, b_cr, b_busy, b_ovf, b_tmo;
   pred_t       b_src, b_u_src, b_u_dst;
   wt_t         b_u_e;
   logic [4:0]  b_fill;
   logic [15:0] b_jobs;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   update_queue #(.DEPTH(16), .TIMEOUT_CYCLES(0)) dut_a (
      .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(a_wr_ready),
      .wr_src(wr_src), .wr_dst(wr_dst), .wr_e(wr_e), .cfg_src(cfg_src),
      .container_done(container_done), .container_reset(a_cr), .src(a_src),
      .u_src(a_u_src), .u_dst(a_u_dst), .u_e(a_u_e), .busy(a_busy), .fill(a_fill),
      .jobs_done(a_jobs), .overflow(a_ovf), .timeout(a_tmo));

   update_queue #(.DEPTH(16), .TIMEOUT_CYCLES(8)) dut_b (
      .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(b_wr_ready),
      .wr_src(wr_src), .wr_dst(wr_dst), .wr_e(wr_e), .cfg_src(cfg_src),
      .container_done(container_done), .container_reset(b_cr), .src(b_src),
      .u_src(b_u_src), .u_dst(b_u_dst), .u_e(b_u_e), .busy(b_busy), .fill(b_fill),
      .jobs_done(b_jobs), .overflow(b_ovf), .timeout(b_tmo));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0; wr_valid = 1'b0; container_done = 1'b0;
      wr_src = '0; wr_dst = '0; wr_e = '0; cfg_src = '0;
      tick(); tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; wr_valid = 1'b0; container_done = 1'b0;
      wr_src = '0; wr_dst = '0; wr_e = '0; cfg_src = '0;
      #3;
      tests++;
      if ({a_cr, a_wr_ready, a_busy, a_ovf, a_tmo} !== 5'b11000) begin
         fails++; $display("FAIL reset_flags got %b want 11000", {a_cr, a_wr_ready, a_busy, a_ovf, a_tmo});
      end
      tests++;
      if (a_fill !== 5'd0 || a_jobs !== 16'd0) begin
         fails++; $display("FAIL reset_counts fill=%0d jobs=%0d want 0 0", a_fill, a_jobs);
      end
      tests++;
      if ({a_src, a_u_src, a_u_dst, a_u_e} !== '0) begin
         fails++; $display("FAIL reset_operands got %h want 0", {a_src, a_u_src, a_u_dst, a_u_e});
      end
      apply_reset();
   endtask

   task automatic test_single();
      apply_reset();
      wr_valid = 1'b1; wr_src = pred_t'(3); wr_dst = pred_t'(5); wr_e = wt_t'(16'h10); cfg_src = '0;
      tick();
      wr_valid = 1'b0;
      tests++;
      if (a_fill !== 5'd1 || a_cr !== 1'b1) begin
         fails++; $display("FAIL single_accept fill=%0d cr=%b want 1 1", a_fill, a_cr);
      end
      tick();
      tests++;
      if (a_cr !== 1'b1 || a_fill !== 5'd0) begin
         fails++; $display("FAIL single_load cr=%b fill=%0d want 1 0", a_cr, a_fill);
      end
      tick();
      tests++;
      if (a_cr !== 1'b0) begin
         fails++; $display("FAIL single_run_start cr=%b want 0", a_cr);
      end
      tests++;
      if (a_u_src !== pred_t'(3) || a_u_dst !== pred_t'(5) || a_u_e !== wt_t'(16'h10) || a_src !== '0) begin
         fails++; $display("FAIL single_operands got %0d %0d %h %0d want 3 5 10 0", a_u_src, a_u_dst, a_u_e, a_src);
      end
      repeat (19) tick();
      tests++;
      if (a_cr !== 1'b0) begin
         fails++; $display("FAIL single_still_running cr=%b want 0", a_cr);
      end
      container_done = 1'b1;
      tick();
      container_done = 1'b0;
      tests++;
      if (a_cr !== 1'b1 || a_jobs !== 16'd1) begin
         fails++; $display("FAIL single_done cr=%b jobs=%0d want 1 1", a_cr, a_jobs);
      end
   endtask

   task automatic test_back_to_back();
      int hi;
      apply_reset();
      cfg_src = pred_t'(9);
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_src = pred_t'(i + 1); wr_dst = pred_t'(i + 10); wr_e = wt_t'(256 * (i + 1) + 7);
         tick();
      end
      wr_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         hi = 0;
         while (a_cr === 1'b1 && hi < 50) begin hi++; tick(); end
         tests++;
         if (hi >= 50) begin
            fails++; $display("FAIL b2b_wait job %0d never started, cr=%b want 0", j, a_cr);
         end
         if (j > 0) begin
            tests++;
            if (hi != 2) begin
               fails++; $display("FAIL b2b_gap job %0d high cycles %0d want 2", j, hi);
            end
         end
         tests++;
         if (a_u_src !== pred_t'(j + 1) || a_u_dst !== pred_t'(j + 10) || a_u_e !== wt_t'(256 * (j + 1) + 7) || a_src !== pred_t'(9)) begin
            fails++; $display("FAIL b2b_order job %0d got %0d %0d %h %0d want %0d %0d %h 9",
                              j, a_u_src, a_u_dst, a_u_e, a_src, j + 1, j + 10, 256 * (j + 1) + 7);
         end
         repeat (4) tick();
         container_done = 1'b1;
         tick();
         container_done = 1'b0;
      end
      tests++;
      if (a_jobs !== 16'd4 || a_fill !== 5'd0 || a_busy !== 1'b0) begin
         fails++; $display("FAIL b2b_end jobs=%0d fill=%0d busy=%b want 4 0 0", a_jobs, a_fill, a_busy);
      end
   endtask

   task automatic test_overflow();
      int n, ef;
      apply_reset();
      for (int i = 0; i < 18; i++) begin
         wr_valid = 1'b1; wr_src = pred_t'(i); wr_dst = pred_t'(i + 32); wr_e = wt_t'(3 * i + 1);
         tick();
         ef = (i == 0) ? 1 : ((i < 16) ? i : 16);
         tests++;
         if (a_fill !== 5'(ef) || a_wr_ready !== (ef != 16) || a_ovf !== (i == 17)) begin
            fails++; $display("FAIL ovf_fill push %0d fill=%0d rdy=%b ovf=%b want %0d %b %b",
                              i, a_fill, a_wr_ready, a_ovf, ef, ef != 16, i == 17);
         end
      end
      wr_valid = 1'b0;
      for (int j = 0; j < 17; j++) begin
         n = 0;
         while (a_cr === 1'b1 && n < 50) begin n++; tick(); end
         tests++;
         if (n >= 50 || a_u_src !== pred_t'(j) || a_u_dst !== pred_t'(j + 32) || a_u_e !== wt_t'(3 * j + 1)) begin
            fails++; $display("FAIL ovf_order job %0d got %0d %0d %h want %0d %0d %h",
                              j, a_u_src, a_u_dst, a_u_e, j, j + 32, 3 * j + 1);
         end
         if (j == 1) begin
            tests++;
            if (a_wr_ready !== 1'b1 || a_fill !== 5'd15) begin
               fails++; $display("FAIL ovf_ready_back rdy=%b fill=%0d want 1 15", a_wr_ready, a_fill);
            end
         end
         container_done = 1'b1;
         tick();
         container_done = 1'b0;
      end
      tests++;
      if (a_jobs !== 16'd17 || a_fill !== 5'd0 || a_ovf !== 1'b1 || a_busy !== 1'b0) begin
         fails++; $display("FAIL ovf_end jobs=%0d fill=%0d ovf=%b busy=%b want 17 0 1 0", a_jobs, a_fill, a_ovf, a_busy);
      end
   endtask

   task automatic test_timeout();
      int n, lo;
      apply_reset();
      wr_valid = 1'b1; wr_src = pred_t'(7); wr_dst = pred_t'(1); wr_e = wt_t'(2);
      tick();
      wr_src = pred_t'(8);
      tick();
      wr_valid = 1'b0;
      n = 0;
      while (b_cr === 1'b1 && n < 50) begin n++; tick(); end
      lo = 0;
      while (b_cr === 1'b0 && lo < 100) begin lo++; tick(); end
      tests++;
      if (lo != 8) begin
         fails++; $display("FAIL tmo_run_length got %0d want 8", lo);
      end
      tests++;
      if (b_tmo !== 1'b1 || b_jobs !== 16'd0) begin
         fails++; $display("FAIL tmo_flags timeout=%b jobs=%0d want 1 0", b_tmo, b_jobs);
      end
      n = 0;
      while (b_cr === 1'b1 && n < 50) begin n++; tick(); end
      tests++;
      if (n >= 50 || b_u_src !== pred_t'(8)) begin
         fails++; $display("FAIL tmo_next_load u_src=%0d waited=%0d want 8", b_u_src, n);
      end
   endtask

   task automatic test_done_at_expiry();
      int n;
      apply_reset();
      wr_valid = 1'b1; wr_src = pred_t'(5); wr_dst = pred_t'(6); wr_e = wt_t'(4);
      tick();
      wr_valid = 1'b0;
      n = 0;
      while (b_cr === 1'b1 && n < 50) begin n++; tick(); end
      repeat (7) tick();
      tests++;
      if (b_cr !== 1'b0) begin
         fails++; $display("FAIL expiry_still_running cr=%b want 0", b_cr);
      end
      container_done = 1'b1;
      tick();
      container_done = 1'b0;
      tests++;
      if (b_jobs !== 16'd1 || b_tmo !== 1'b0 || b_cr !== 1'b1) begin
         fails++; $display("FAIL expiry_done jobs=%0d timeout=%b cr=%b want 1 0 1", b_jobs, b_tmo, b_cr);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      cfg_src = pred_t'(6);
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_src = pred_t'(i + 1); wr_dst = pred_t'(i + 2); wr_e = wt_t'(i + 3);
         tick();
      end
      wr_valid = 1'b0;
      tests++;
      if (a_fill !== 5'd3 || a_cr !== 1'b0 || a_src !== pred_t'(6)) begin
         fails++; $display("FAIL arst_pre fill=%0d cr=%b src=%0d want 3 0 6", a_fill, a_cr, a_src);
      end
      #2 reset_n = 1'b0;
      #1;
      tests++;
      if (a_cr !== 1'b1 || a_fill !== 5'd0 || a_busy !== 1'b0 || a_wr_ready !== 1'b1) begin
         fails++; $display("FAIL arst_now cr=%b fill=%0d busy=%b rdy=%b want 1 0 0 1", a_cr, a_fill, a_busy, a_wr_ready);
      end
      tests++;
      if ({a_src, a_u_src, a_u_dst, a_u_e} !== '0) begin
         fails++; $display("FAIL arst_operands got %h want 0", {a_src, a_u_src, a_u_dst, a_u_e});
      end
      #1 reset_n = 1'b1;
      repeat (5) tick();
      tests++;
      if (a_cr !== 1'b1 || a_fill !== 5'd0 || a_busy !== 1'b0 || a_jobs !== 16'd0) begin
         fails++; $display("FAIL arst_after cr=%b fill=%0d busy=%b jobs=%0d want 1 0 0 0", a_cr, a_fill, a_busy, a_jobs);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_timeout();
      test_done_at_expiry();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit reached at %0t, bench did not complete", $time);
      $fatal(1);
   end
endmodule
